// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared opcodes, FSM state type and frame sizing for the SPI register bank
package spi_reg_pkg;

    localparam logic SPI_OP_WRITE = 1'b1;
    localparam logic SPI_OP_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_t;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with one history flop for rise/fall pulses
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // chain_q[0] is the newest sample; chain_q[STAGES] is the history flop.
    logic [STAGES:0] chain_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= {(STAGES + 1){RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-1:0], d_i};
        end
    end

    assign level_o = chain_q[STAGES-1];
    assign rise_o  = chain_q[STAGES-1] & ~chain_q[STAGES];
    assign fall_o  = ~chain_q[STAGES-1] & chain_q[STAGES];

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 peripheral exposing a read/write configuration register bank
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int FRAME = frame_len(ADDR_W, DATA_W);
    localparam int HDR   = 1 + ADDR_W;
    localparam int CNT_W = $clog2(FRAME + 2);

    localparam logic [CNT_W-1:0]  HDR_C   = CNT_W'(HDR);
    localparam logic [CNT_W-1:0]  FRAME_C = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0]  OVER_C  = CNT_W'(FRAME + 1);
    localparam logic [ADDR_W:0]   NREGS_C = (ADDR_W + 1)'(NUM_REGS);

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic edges_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
        .clk(clk), .rst_n(rst_n), .d_i(ncs),
        .level_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .level_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi_sync (
        .clk(clk), .rst_n(rst_n), .d_i(copi),
        .level_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    assign edges_unused = ^{sclk_s, copi_rise, copi_fall};

    spi_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [FRAME-1:0]           shift_q, shift_d;
    logic [DATA_W-1:0]          tx_q, tx_d;
    logic                       rd_q, rd_d;
    logic                       cipo_q, cipo_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;

    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;

    assign frame_rw   = shift_q[FRAME-1];
    assign frame_addr = shift_q[FRAME-2 -: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rd_d        = rd_q;
        cipo_d      = cipo_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;

        unique case (state_q)
            ST_IDLE, ST_SHIFT: begin
                // A falling ncs while already shifting is a glitch: restart the frame.
                if (ncs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                    tx_d    = '0;
                    rd_d    = 1'b0;
                    cipo_d  = 1'b0;
                end else if (state_q == ST_SHIFT && !ncs_rise && sclk_rise) begin
                    shift_d = {shift_q[FRAME-2:0], copi_s};
                    if (cnt_q != OVER_C) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_d == HDR_C && shift_d[ADDR_W] == SPI_OP_READ) begin
                        rd_d = 1'b1;
                        tx_d = '0;
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (shift_d[ADDR_W-1:0] == ADDR_W'(k)) begin
                                tx_d = regs_q[k*DATA_W +: DATA_W];
                            end
                        end
                    end
                end else if (state_q == ST_SHIFT && !ncs_rise && sclk_fall) begin
                    if (rd_q && cnt_q >= HDR_C && cnt_q <= FRAME_C) begin
                        cipo_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end else begin
                        cipo_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cipo_d  = 1'b0;
                rd_d    = 1'b0;
                if (cnt_q == FRAME_C && frame_rw == SPI_OP_WRITE
                    && {1'b0, frame_addr} < NREGS_C) begin
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = frame_addr;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (frame_addr == ADDR_W'(k)) begin
                            regs_d[k*DATA_W +: DATA_W] = frame_data;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ncs rising ends the frame from any state and masks a coincident sclk edge.
        if (ncs_rise) begin
            state_d = ST_DONE;
            cipo_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            rd_q        <= 1'b0;
            cipo_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rd_q        <= rd_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign cipo      = cipo_q;
    assign cipo_oe   = ~ncs_s;
    assign regs      = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule
